spi_slave_fifo: RTL

- Parametrised successor to the single-byte SPI slave driver: word-width-, mode- and depth-configurable SPI slave with independent RX and TX FIFOs.
- Sits between external SPI master pins and on-chip logic in the clk_25mhz domain.
- Host side uses valid/ready streams.
- Reports FIFO levels plus sticky overrun/underrun status.

---
 rtl/spi_slave_fifo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
// SPI slave with RX/TX FIFOs, configurable word width, SPI mode and FIFO depth.
// Optional macro SPI_SLAVE_ECHO_EN: on TX underrun, shift out the last received word instead of UNDERRUN_FILL.
module spi_slave_fifo #(
    parameter int                DATA_W        = 8,
    parameter int                FIFO_DEPTH    = 16,
    parameter int                CPOL          = 0,
    parameter int                CPHA          = 0,
    parameter logic [DATA_W-1:0] UNDERRUN_FILL = '0
) (
    input  logic                          clk_25mhz,
    input  logic                          rst_n,
    input  logic                          sck,
    input  logic                          mosi,
    input  logic                          ssel,
    output logic                          miso,
    output logic                          miso_oe,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic                          rx_overrun,
    output logic                          tx_underrun,
    input  logic                          status_clr,
    output logic                          frame_active
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W);
    localparam logic              IDLE_LVL = (CPOL != 0);
    localparam logic [LW-1:0]     FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_nx;

    logic [2:0] sck_sr;
    logic [1:0] mosi_sr;
    logic [2:0] ssel_sr;
    logic       sck_s, sck_h, mosi_s, ssel_s, ssel_h;
    logic       sck_lead, sck_trail, sample_edge, shift_edge;
    logic       ssel_fall, ssel_rise;

    logic [DATA_W-1:0] rx_shift, tx_shift, rx_word, rx_next;
    logic [DATA_W-1:0] load_val, fill_word;
    logic [CW-1:0]     bit_cnt;
    logic              rx_push_pend;
    logic              frame_start, in_frame, sample_evt, word_done, load_word;

    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wr, rx_rd, tx_wr, tx_rd;
    logic              rx_push, rx_pop, rx_full, overrun_evt;
    logic              tx_push, tx_pop, tx_empty, underrun_evt;

    // sck and ssel keep a history flop for edge detection; mosi only needs to stay aligned with sck_s
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr  <= {3{IDLE_LVL}};
            mosi_sr <= '0;
            ssel_sr <= '1;
        end else begin
            sck_sr  <= {sck_sr[1:0], sck};
            mosi_sr <= {mosi_sr[0], mosi};
            ssel_sr <= {ssel_sr[1:0], ssel};
        end
    end

    assign sck_s  = sck_sr[1];
    assign sck_h  = sck_sr[2];
    assign mosi_s = mosi_sr[1];
    assign ssel_s = ssel_sr[1];
    assign ssel_h = ssel_sr[2];

    assign sck_lead    = (sck_s != IDLE_LVL) && (sck_h == IDLE_LVL);
    assign sck_trail   = (sck_s == IDLE_LVL) && (sck_h != IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? sck_trail : sck_lead;
    assign shift_edge  = (CPHA != 0) ? sck_lead  : sck_trail;
    assign ssel_fall   = ssel_h & ~ssel_s;
    assign ssel_rise   = ~ssel_h & ssel_s;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ssel_fall) state_nx = ACTIVE;
            ACTIVE:  if (ssel_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign frame_start = (state == IDLE) && ssel_fall;
    assign in_frame    = (state == ACTIVE) && !ssel_rise;
    assign sample_evt  = in_frame && sample_edge;
    assign word_done   = sample_evt && (bit_cnt == LAST_BIT);
    assign load_word   = frame_start || word_done;
    assign rx_next     = {rx_shift[DATA_W-2:0], mosi_s};

    assign tx_empty     = (tx_level == '0);
    assign tx_pop       = load_word && !tx_empty;
    assign underrun_evt = load_word && tx_empty;
    assign load_val     = tx_empty ? fill_word : tx_mem[tx_rd];

`ifdef SPI_SLAVE_ECHO_EN
    logic [DATA_W-1:0] last_word;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n)         last_word <= '0;
        else if (word_done) last_word <= rx_next;
    end

    // The word finishing this cycle is the most recent one, so bypass the register
    assign fill_word = word_done ? rx_next : last_word;
`else
    assign fill_word = UNDERRUN_FILL;
`endif

    // The shift edge at bit 0 is skipped so a freshly loaded MSB stays on miso
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift     <= '0;
            tx_shift     <= '0;
            rx_word      <= '0;
            bit_cnt      <= '0;
            rx_push_pend <= 1'b0;
        end else begin
            rx_push_pend <= word_done;
            if (frame_start) begin
                tx_shift <= load_val;
                bit_cnt  <= '0;
            end else if ((state == ACTIVE) && ssel_rise) begin
                bit_cnt <= '0;
            end else if (sample_evt) begin
                rx_shift <= rx_next;
                if (word_done) begin
                    bit_cnt  <= '0;
                    rx_word  <= rx_next;
                    tx_shift <= load_val;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else if (in_frame && shift_edge && (bit_cnt != '0)) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign miso         = (state == ACTIVE) ? tx_shift[DATA_W-1] : 1'b0;
    assign miso_oe      = (state == ACTIVE);
    assign frame_active = (state == ACTIVE);

    assign rx_valid    = (rx_level != '0);
    assign rx_full     = (rx_level == FULL_LVL);
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_push     = rx_push_pend && (!rx_full || rx_pop);
    assign overrun_evt = rx_push_pend && rx_full && !rx_pop;
    assign rx_data     = rx_mem[rx_rd];

    always_ff @(posedge clk_25mhz) begin
        if (rx_push) rx_mem[rx_wr] <= rx_word;
    end

    // A new error event beats a simultaneous status_clr
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr      <= '0;
            rx_rd      <= '0;
            rx_level   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_level <= rx_level + LW'(1);
                2'b01:   rx_level <= rx_level - LW'(1);
                default: rx_level <= rx_level;
            endcase
            if (overrun_evt)     rx_overrun <= 1'b1;
            else if (status_clr) rx_overrun <= 1'b0;
        end
    end

    assign tx_ready = (tx_level != FULL_LVL);
    assign tx_push  = tx_valid && tx_ready;

    always_ff @(posedge clk_25mhz) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_level    <= '0;
            tx_underrun <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_level <= tx_level + LW'(1);
                2'b01:   tx_level <= tx_level - LW'(1);
                default: tx_level <= tx_level;
            endcase
            if (underrun_evt)    tx_underrun <= 1'b1;
            else if (status_clr) tx_underrun <= 1'b0;
        end
    end

endmodule
